// File: rtl/inst_fetch_unit_pkg.sv
// =============================================================================
// inst_fetch_unit_pkg : shared types and helpers for the instruction fetch stage
// Rev 1.0
// =============================================================================
`default_nettype none

package inst_fetch_unit_pkg;

    localparam int INST_W          = 32;
    localparam int ADDR_W          = 32;
    localparam int FETCH_BLK_BYTES = 8;

    typedef struct packed {
        logic [ADDR_W-4:0] blk_addr;
        logic              first_off;
        logic [63:0]       data;
    } fetch_entry_t;

    function automatic logic [ADDR_W-1:0] next_blk_addr(input logic [ADDR_W-1:0] addr);
        return (addr & ~ADDR_W'(FETCH_BLK_BYTES - 1)) + ADDR_W'(FETCH_BLK_BYTES);
    endfunction

endpackage

`default_nettype wire

// File: rtl/inst_fetch_unit_fetch_resp_fifo.sv
// =============================================================================
// fetch_resp_fifo : in-order response queue with clear, depth = power of two
// Rev 1.0
// =============================================================================
`default_nettype none

module fetch_resp_fifo
    import inst_fetch_unit_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PW   = $clog2(DEPTH),
    localparam int CW   = PW + 1
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clear_i,
    input  logic         push_i,
    input  fetch_entry_t wdata_i,
    input  logic         pop_i,
    output fetch_entry_t rdata_o,
    output logic [CW-1:0] count_o,
    output logic         empty_o
);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] wr_ptr_q;
    logic [PW-1:0] rd_ptr_q;
    logic [CW-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push_i && !clear_i) begin
            mem_q[wr_ptr_q] <= wdata_i;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else if (clear_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) wr_ptr_q <= wr_ptr_q + PW'(1);
            if (pop_i)  rd_ptr_q <= rd_ptr_q + PW'(1);
            count_q <= count_q + CW'(push_i) - CW'(pop_i);
        end
    end

    assign rdata_o = mem_q[rd_ptr_q];
    assign count_o = count_q;
    assign empty_o = (count_q == '0);

endmodule

`default_nettype wire

// File: rtl/inst_fetch_unit.sv
// =============================================================================
// inst_fetch_unit : fetch PC, cache block requests, response queue, 2-wide delivery
// Build macro FETCH_BYPASS_EN: empty-queue responses go straight to the outputs.
// Rev 1.0
// =============================================================================
`default_nettype none

module inst_fetch_unit
    import inst_fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC        = 32'hBFC0_0000,
    parameter int          MAX_OUTSTANDING = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    input  logic        buffer_full_i,
    output logic        ireq_valid_o,
    input  logic        ireq_ready_i,
    output logic [31:0] ireq_addr_o,
    input  logic        irsp_valid_i,
    input  logic [63:0] irsp_data_i,
    output logic [31:0] inst1_o,
    output logic [31:0] inst2_o,
    output logic [31:0] inst1_addr_o,
    output logic [31:0] inst2_addr_o,
    output logic        inst1_valid_o,
    output logic        inst2_valid_o
);

    localparam int CW = $clog2(MAX_OUTSTANDING) + 1;

    logic [31:0]   pc_q, pc_d;
    logic [28:0]   rsp_blk_q, rsp_blk_d;
    logic          rsp_off_q, rsp_off_d;
    logic [CW-1:0] out_cnt_q, out_cnt_d;
    logic [CW-1:0] drop_cnt_q, drop_cnt_d;
    fetch_entry_t  out_q, out_d;
    logic          out_vld_q, out_vld_d;

    logic          q_push, q_pop, q_clear, q_empty;
    logic [CW-1:0] q_count;
    fetch_entry_t  q_rdata, rsp_entry;
    logic          ireq_hs, rsp_keep;
    logic [CW:0]   occupancy;

    fetch_resp_fifo #(.DEPTH(MAX_OUTSTANDING)) u_resp_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (q_clear),
        .push_i  (q_push),
        .wdata_i (rsp_entry),
        .pop_i   (q_pop),
        .rdata_o (q_rdata),
        .count_o (q_count),
        .empty_o (q_empty)
    );

    assign occupancy    = (CW+1)'(out_cnt_q) + (CW+1)'(q_count);
    assign ireq_valid_o = rst_n && !redirect_i && (occupancy < (CW+1)'(MAX_OUTSTANDING));
    assign ireq_addr_o  = pc_q & 32'hFFFF_FFF8;
    assign ireq_hs      = ireq_valid_o && ireq_ready_i;
    assign rsp_keep     = irsp_valid_i && !redirect_i && (drop_cnt_q == '0);
    assign rsp_entry    = '{blk_addr: rsp_blk_q, first_off: rsp_off_q, data: irsp_data_i};

    always_comb begin
        pc_d       = pc_q;
        rsp_blk_d  = rsp_blk_q;
        rsp_off_d  = rsp_off_q;
        out_cnt_d  = out_cnt_q + CW'(ireq_hs) - CW'(irsp_valid_i);
        drop_cnt_d = drop_cnt_q;
        out_d      = out_q;
        out_vld_d  = 1'b0;
        q_push     = 1'b0;
        q_pop      = 1'b0;
        q_clear    = 1'b0;

        if (redirect_i) begin
            pc_d      = redirect_pc_i & 32'hFFFF_FFFC;
            rsp_blk_d = redirect_pc_i[31:3];
            rsp_off_d = redirect_pc_i[2];
            q_clear   = 1'b1;
            // Responses already marked for dropping are part of out_cnt, so the
            // new discard count is every in-flight response not arriving now.
            drop_cnt_d = out_cnt_q - CW'(irsp_valid_i);
        end else begin
            if (ireq_hs) begin
                pc_d = next_blk_addr(ireq_addr_o);
            end
            if (irsp_valid_i && (drop_cnt_q != '0)) begin
                drop_cnt_d = drop_cnt_q - CW'(1);
            end
            if (rsp_keep) begin
                rsp_blk_d = rsp_blk_q + 29'd1;
                rsp_off_d = 1'b0;
            end
            if (!q_empty && !buffer_full_i) begin
                q_pop     = 1'b1;
                out_d     = q_rdata;
                out_vld_d = 1'b1;
            end
`ifdef FETCH_BYPASS_EN
            if (rsp_keep) begin
                if (q_empty && !buffer_full_i) begin
                    out_d     = rsp_entry;
                    out_vld_d = 1'b1;
                end else begin
                    q_push = 1'b1;
                end
            end
`else
            q_push = rsp_keep;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_q       <= RESET_PC & 32'hFFFF_FFFC;
            rsp_blk_q  <= RESET_PC[31:3];
            rsp_off_q  <= RESET_PC[2];
            out_cnt_q  <= '0;
            drop_cnt_q <= '0;
            out_q      <= '0;
            out_vld_q  <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            rsp_blk_q  <= rsp_blk_d;
            rsp_off_q  <= rsp_off_d;
            out_cnt_q  <= out_cnt_d;
            drop_cnt_q <= drop_cnt_d;
            out_q      <= out_d;
            out_vld_q  <= out_vld_d;
        end
    end

    assign inst1_o       = out_q.data[31:0];
    assign inst2_o       = out_q.data[63:32];
    assign inst1_addr_o  = {out_q.blk_addr, 3'b000};
    assign inst2_addr_o  = {out_q.blk_addr, 3'b100};
    assign inst1_valid_o = out_vld_q && !out_q.first_off;
    assign inst2_valid_o = out_vld_q;

endmodule

`default_nettype wire

// File: tb/tb_inst_fetch_unit.sv
// =============================================================================
// tb_inst_fetch_unit : randomized/directed bench with queue-level fetch model
// Rev 1.0
// =============================================================================
`default_nettype none

module tb_inst_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'hBFC0_0000;
    localparam int          MAX      = 2;
`ifdef FETCH_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        redirect_i;
    logic [31:0] redirect_pc_i;
    logic        buffer_full_i;
    logic        ireq_valid_o;
    logic        ireq_ready_i;
    logic [31:0] ireq_addr_o;
    logic        irsp_valid_i;
    logic [63:0] irsp_data_i;
    logic [31:0] inst1_o, inst2_o, inst1_addr_o, inst2_addr_o;
    logic        inst1_valid_o, inst2_valid_o;

    inst_fetch_unit #(.RESET_PC(RESET_PC), .MAX_OUTSTANDING(MAX)) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .redirect_i    (redirect_i),
        .redirect_pc_i (redirect_pc_i),
        .buffer_full_i (buffer_full_i),
        .ireq_valid_o  (ireq_valid_o),
        .ireq_ready_i  (ireq_ready_i),
        .ireq_addr_o   (ireq_addr_o),
        .irsp_valid_i  (irsp_valid_i),
        .irsp_data_i   (irsp_data_i),
        .inst1_o       (inst1_o),
        .inst2_o       (inst2_o),
        .inst1_addr_o  (inst1_addr_o),
        .inst2_addr_o  (inst2_addr_o),
        .inst1_valid_o (inst1_valid_o),
        .inst2_valid_o (inst2_valid_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] addr;
        bit          keep;
        bit          off;
        logic [63:0] data;
        int          acc;
    } blk_t;

    blk_t        pend[$];   // requests accepted by the cache, response not yet returned
    blk_t        wq[$];     // kept blocks waiting inside the fetch unit
    blk_t        shown;
    bit          shown_v;
    logic [31:0] exp_pc;
    bit          next_off;
    int          cyc;
    int          n_checks;
    int          n_errors;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        wq.delete();
        shown_v  = 1'b0;
        exp_pc   = RESET_PC & 32'hFFFF_FFF8;
        next_off = RESET_PC[2];
    endtask

    task automatic step(input bit red, input logic [31:0] rpc, input bit bf,
                        input bit rdy, input bit rsp_ok);
        bit   rsp, exp_rv, hs, kept, nxt_v;
        blk_t r, nxt, nb;
        redirect_i    = red;
        redirect_pc_i = rpc;
        buffer_full_i = bf;
        ireq_ready_i  = rdy;
        rsp           = rsp_ok && (pend.size() > 0) && (pend[0].acc < cyc);
        irsp_valid_i  = rsp;
        irsp_data_i   = rsp ? pend[0].data : {$urandom, $urandom};
        #2;
        chk("inst2_valid", 64'(inst2_valid_o), 64'(shown_v));
        if (shown_v) begin
            chk("inst1_valid", 64'(inst1_valid_o), 64'(!shown.off));
            chk("inst1_addr", 64'(inst1_addr_o), 64'(shown.addr));
            chk("inst2_addr", 64'(inst2_addr_o), 64'(shown.addr + 32'd4));
            chk("inst1", 64'(inst1_o), 64'(shown.data[31:0]));
            chk("inst2", 64'(inst2_o), 64'(shown.data[63:32]));
        end else begin
            chk("inst1_valid_idle", 64'(inst1_valid_o), 64'd0);
        end
        exp_rv = !red && ((pend.size() + wq.size()) < MAX);
        chk("ireq_valid", 64'(ireq_valid_o), 64'(exp_rv));
        if (exp_rv) chk("ireq_addr", 64'(ireq_addr_o), 64'(exp_pc));

        hs    = exp_rv && rdy;
        kept  = 1'b0;
        nxt_v = 1'b0;
        nxt   = shown;
        if (rsp) begin
            r    = pend.pop_front();
            kept = r.keep && !red;
        end
        if (red) begin
            wq.delete();
            foreach (pend[i]) pend[i].keep = 1'b0;
            exp_pc   = rpc & 32'hFFFF_FFF8;
            next_off = rpc[2];
        end else begin
            if (hs) begin
                nb.addr = exp_pc;
                nb.keep = 1'b1;
                nb.off  = next_off;
                nb.data = {$urandom, $urandom};
                nb.acc  = cyc;
                pend.push_back(nb);
                exp_pc   = exp_pc + 32'd8;
                next_off = 1'b0;
            end
            if (wq.size() > 0 && !bf) begin
                nxt   = wq.pop_front();
                nxt_v = 1'b1;
            end else if (kept && BYPASS && !bf) begin
                nxt   = r;
                nxt_v = 1'b1;
                kept  = 1'b0;
            end
            if (kept) wq.push_back(r);
        end
        @(posedge clk);
        #1;
        cyc++;
        shown   = nxt;
        shown_v = nxt_v;
    endtask

    initial begin
        n_checks      = 0;
        n_errors      = 0;
        cyc           = 0;
        rst_n         = 1'b0;
        redirect_i    = 1'b0;
        redirect_pc_i = 32'h0;
        buffer_full_i = 1'b0;
        ireq_ready_i  = 1'b0;
        irsp_valid_i  = 1'b0;
        irsp_data_i   = 64'h0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ireq_valid", 64'(ireq_valid_o), 64'd0);
        chk("rst_inst2_valid", 64'(inst2_valid_o), 64'd0);
        chk("rst_inst1_valid", 64'(inst1_valid_o), 64'd0);
        chk("rst_inst1_addr", 64'(inst1_addr_o), 64'd0);
        rst_n = 1'b1;

        // Sequential fetch from reset with a one-cycle cache.
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Redirect into the upper half of a block.
        step(1'b1, 32'h8000_0014, 1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Redirect with requests still in flight; their responses must vanish.
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h4000_0100, 1'b0, 1'b1, 1'b0);
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Downstream back-pressure for five cycles, then drain.
        repeat (5) step(1'b0, 32'h0, 1'b1, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Redirect coinciding with a response.
        repeat (2) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b0);
        step(1'b1, 32'h1234_5678, 1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Address wrap at the top of memory.
        step(1'b1, 32'hFFFF_FFFC, 1'b0, 1'b1, 1'b1);
        repeat (6) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Random traffic.
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 19) == 0, $urandom, $urandom_range(0, 3) == 0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 2) != 0);
        end
        // Reset in the middle of a burst.
        repeat (3) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        redirect_i   = 1'b0;
        irsp_valid_i = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_inst2_valid", 64'(inst2_valid_o), 64'd0);
        chk("midrst_inst1_valid", 64'(inst1_valid_o), 64'd0);
        chk("midrst_ireq_valid", 64'(ireq_valid_o), 64'd0);
        repeat (2) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        model_reset();
        rst_n = 1'b1;
        repeat (8) step(1'b0, 32'h0, 1'b0, 1'b1, 1'b1);
        // Stop requesting and let everything in flight drain.
        repeat (10) step(1'b0, 32'h0, 1'b0, 1'b0, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
